max6675_emulator: RTL and testbench
===================================

# max6675_emulator

Synthesizable MAX6675 thermocouple-converter emulator. It acts as the SPI responder on the same 3-wire link that the controller's MAX6675 reader drives as initiator. It sits in the FPGA test fabric, wired in place of the physical chip, so the autoclave temperature loop can run hardware-in-the-loop from a programmable temperature value. It samples the host's `cs`/`sclk` in the system clock domain, snapshots a 16-bit MAX6675 frame on `cs` fall and shifts it out MSB-first on `miso`.

## Interface
- `CONV_CYCLES`, default 22_000_000: conversion time in `clk` cycles (220 ms at 100 MHz).
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  asynchronous, active-high reset.
- `cs`  in  1  host chip-select, active low, asynchronous to `clk`.
- `sclk`  in  1  host serial clock, asynchronous to `clk`, either idle level.
- `temp_code`  in  12  temperature in 0.25 °C units (0..4095).
- `tc_open`  in  1  thermocouple-open flag to report.
- `miso`  out  1  serial data to host.
- `miso_oe`  out  1  output enable, high while `cs` is low; the top level tri-states on low.
- `frame_done`  out  1  1-cycle pulse on a completed read.
- `conv_ready`  out  1  a conversion finished since the last `cs` rise.

## Operation
- Frame: D15 = 0, D14..D3 = `temp_code`, D2 = `tc_open`, D1 = 0 (device ID), D0 = 0.
- `cs` and `sclk` each pass through a 2-flop synchronizer and a 1-flop edge detector. Synchronizer flops reset to 1.
- States:
  - CONV (`cs` high, timer running)
  - READY (`cs` high, timer expired, `conv_ready`=1)
  - SHIFT (`cs` low)
- CONV → READY when the timer reaches 0. The timer is loaded with `CONV_CYCLES-1` on reset and on every `cs` rise.
- CONV/READY → SHIFT on `cs` fall:
  - the frame is latched into the 16-bit shift register;
  - `miso` = D15; `miso_oe`=1;
  - the rise counter is cleared.
- In SHIFT:
  - each `sclk` rising edge increments a 5-bit rise counter, saturating at 31;
  - each `sclk` falling edge shifts left, filling with 0, but only when rise counter > 0. A leading falling edge from an idle-high `sclk` therefore never drops D15.
  - After 16 bits, `miso` stays 0.
- SHIFT → CONV on `cs` rise:
  - `miso_oe`=0, `miso`=0;
  - `frame_done` pulses only if rise counter ≥ 16; an aborted frame gives no pulse;
  - `conv_ready` clears and the timer reloads.
- `cs` fall and `sclk` edge in the same cycle: the `cs` fall wins and the `sclk` edge is ignored.
- Mid-operation `rst`: immediate return to CONV with all outputs 0. If `cs` is held low through release, a `cs` fall is detected 3 cycles after release and a fresh frame starts.

## Timing
- Reset values:
  - `miso`=0, `miso_oe`=0, `frame_done`=0, `conv_ready`=0
  - shift register 0, rise counter 0
- Latency: `miso` update or frame latch occurs 3 `clk` cycles after the pin edge (2 sync + 1 detect).
- Host requirement: `sclk` half-period ≥ 4 `clk`; `cs`-fall to first `sclk` edge ≥ 4 `clk`.
- `frame_done` is asserted on the cycle the `cs` rise is detected.
- `conv_ready` rises `CONV_CYCLES` cycles after reset release or after detection of the `cs` rise.

## Configuration
- `MAX6675_EMU_CONV_DELAY_EN` defined:
  - the frame is refreshed from `temp_code`/`tc_open` only when `cs` falls in READY;
  - a `cs` fall in CONV re-sends the previous frame, which is 0 after reset. This matches the real chip's behaviour when the conversion is aborted.
- Undefined:
  - the timer is removed and `conv_ready` is tied to 1;
  - every `cs` fall snapshots the live inputs.

## Structure
- `max6675_pkg`:
  - state enum (CONV/READY/SHIFT);
  - frame bit positions: `TEMP_MSB`=14, `TEMP_LSB`=3, `OPEN_BIT`=2;
  - `FRAME_BITS`=16;
  - `SYNC_STAGES`=2.
- Sub-module `edge_sync`: parameterized reset value, synchronizer plus registered rise/fall pulses. Instantiated once for `cs` and once for `sclk`.

## Test plan
- `temp_code`=12'h064, `tc_open`=0, host read with idle-high `sclk`, 16 rising edges → captured word 16'h0320, `frame_done` pulse once.
- `temp_code`=12'hFFF, `tc_open`=1, idle-low `sclk` → 16'h7FFC.
- With `_EN` and `CONV_CYCLES`=1000:
  - read at cycle 500 after reset → 16'h0000;
  - read after `conv_ready` → live frame;
  - second read 10 cycles later → identical to the previous frame.
- `cs` rises after 8 rising edges → no `frame_done`, `miso_oe`=0 within 3 cycles, `conv_ready`=0.
- 20 rising edges in one frame → bits 17–20 read 0, `frame_done`=1.
- `rst` pulsed during bit 5 with `cs` held low → outputs 0 during reset, new frame starts with D15 3 cycles after release.

Source files
------------

// File: rtl/max6675_pkg.sv
// Shared types and frame layout for the MAX6675 emulator.
// Frame: D15=0, D14..D3=temperature, D2=open flag, D1..D0=0.
package max6675_pkg;

  typedef enum logic [1:0] {
    ST_CONV  = 2'd0,
    ST_READY = 2'd1,
    ST_SHIFT = 2'd2
  } emu_state_t;

  localparam int FRAME_BITS  = 16;
  localparam int TEMP_MSB    = 14;
  localparam int TEMP_LSB    = 3;
  localparam int OPEN_BIT    = 2;
  localparam int TEMP_W      = TEMP_MSB - TEMP_LSB + 1;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 5;

  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [TEMP_W-1:0] temp,
    input logic              open_flag
  );
    logic [FRAME_BITS-1:0] frame;
    frame                    = {FRAME_BITS{1'b0}};
    frame[TEMP_MSB:TEMP_LSB] = temp;
    frame[OPEN_BIT]          = open_flag;
    return frame;
  endfunction

endpackage

// File: rtl/max6675_emulator_edge_sync.sv
// Two-flop synchronizer plus one detector flop; rise/fall pulses are
// decoded from the last sync flop and the detector flop.
module edge_sync
  import max6675_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchronizer chain and previous-level flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{RST_VAL}};
      prev_r <= RST_VAL;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;
  assign fall = ~sync_r[SYNC_STAGES-1] & prev_r;

endmodule

// File: rtl/max6675_emulator.sv
// MAX6675 SPI responder emulator: snapshots a frame on cs fall, shifts MSB-first.
// Optional conversion-delay model enabled by defining MAX6675_EMU_CONV_DELAY_EN.
module max6675_emulator
  import max6675_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 22_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sclk,
  input  logic [TEMP_W-1:0] temp_code,
  input  logic              tc_open,
  output logic              miso,
  output logic              miso_oe,
  output logic              frame_done,
  output logic              conv_ready
);

  localparam logic [CNT_W-1:0] CNT_MAX  = 5'd31;
  localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;

  emu_state_t            state_r;
  logic [FRAME_BITS-1:0] shift_r;
  logic [FRAME_BITS-1:0] live_frame_s;
  logic [FRAME_BITS-1:0] next_frame_s;
  logic [CNT_W-1:0]      rise_cnt_r;
  logic                  conv_done_s;
  logic                  cs_rise_s;
  logic                  cs_fall_s;
  logic                  sclk_rise_s;
  logic                  sclk_fall_s;

  edge_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (cs),
    .rise (cs_rise_s),
    .fall (cs_fall_s)
  );

  edge_sync #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .rise (sclk_rise_s),
    .fall (sclk_fall_s)
  );

  assign live_frame_s = build_frame(temp_code, tc_open);

`ifdef MAX6675_EMU_CONV_DELAY_EN
  localparam int TIMER_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(CONV_CYCLES - 1);

  logic [TIMER_W-1:0]    timer_r;
  logic [FRAME_BITS-1:0] frame_r;

  assign conv_done_s = (timer_r == {TIMER_W{1'b0}});

  // An aborted conversion re-sends the last completed frame.
  always_comb begin
    next_frame_s = frame_r;
    if (state_r == ST_READY) begin
      next_frame_s = live_frame_s;
    end else begin
      next_frame_s = frame_r;
    end
  end

  // Conversion timer, ready flag and last-converted frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r    <= TIMER_RELOAD;
      conv_ready <= 1'b0;
      frame_r    <= {FRAME_BITS{1'b0}};
    end else begin
      if (cs_rise_s) begin
        timer_r    <= TIMER_RELOAD;
        conv_ready <= 1'b0;
      end else if (state_r == ST_CONV && !cs_fall_s) begin
        if (conv_done_s) begin
          conv_ready <= 1'b1;
        end else begin
          timer_r <= timer_r - TIMER_W'(1);
        end
      end else begin
        timer_r <= timer_r;
      end
      if (cs_fall_s && state_r == ST_READY) begin
        frame_r <= live_frame_s;
      end else begin
        frame_r <= frame_r;
      end
    end
  end
`else
  assign conv_done_s  = 1'b1;
  assign next_frame_s = live_frame_s;

  // Without the delay model a conversion is always available.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_ready <= 1'b0;
    end else begin
      conv_ready <= 1'b1;
    end
  end
`endif

  // Main responder FSM; a cs edge always takes priority over an sclk edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_CONV;
      shift_r    <= {FRAME_BITS{1'b0}};
      rise_cnt_r <= {CNT_W{1'b0}};
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_r)
        ST_CONV, ST_READY: begin
          if (cs_fall_s) begin
            shift_r    <= next_frame_s;
            miso       <= next_frame_s[FRAME_BITS-1];
            miso_oe    <= 1'b1;
            rise_cnt_r <= {CNT_W{1'b0}};
            state_r    <= ST_SHIFT;
          end else if (state_r == ST_CONV && conv_done_s) begin
            state_r <= ST_READY;
          end else begin
            state_r <= state_r;
          end
        end
        ST_SHIFT: begin
          if (cs_rise_s) begin
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            frame_done <= (rise_cnt_r >= CNT_FULL);
            state_r    <= ST_CONV;
          end else begin
            if (sclk_rise_s && rise_cnt_r != CNT_MAX) begin
              rise_cnt_r <= rise_cnt_r + 5'd1;
            end else begin
              rise_cnt_r <= rise_cnt_r;
            end
            // A falling edge before any rise (idle-high sclk) must keep D15.
            if (sclk_fall_s && rise_cnt_r != {CNT_W{1'b0}}) begin
              shift_r <= {shift_r[FRAME_BITS-2:0], 1'b0};
              miso    <= shift_r[FRAME_BITS-2];
            end else begin
              shift_r <= shift_r;
            end
          end
        end
        default: begin
          state_r <= ST_CONV;
          miso    <= 1'b0;
          miso_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max6675_emulator.sv
// Directed + randomized bench for max6675_emulator with a frame-level reference model.
module tb_max6675_emulator;

  localparam int CONV = 1000;
`ifdef MAX6675_EMU_CONV_DELAY_EN
  localparam bit DELAY_EN = 1'b1;
`else
  localparam bit DELAY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b1;
  logic        sclk = 1'b1;
  logic [11:0] temp_code = 12'h000;
  logic        tc_open = 1'b0;
  logic        miso, miso_oe, frame_done, conv_ready;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          last_ref = 0;
  logic [15:0] prev_frame = 16'h0000;

  max6675_emulator #(.CONV_CYCLES(CONV)) dut (
    .clk        (clk),
    .rst        (rst),
    .cs         (cs),
    .sclk       (sclk),
    .temp_code  (temp_code),
    .tc_open    (tc_open),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .frame_done (frame_done),
    .conv_ready (conv_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // MAX6675 word from the datasheet layout: temperature * 8 + open * 4.
  function automatic logic [15:0] model_frame(input logic [11:0] t, input logic o);
    return {4'h0, t} * 16'd8 + (o ? 16'd4 : 16'd0);
  endfunction

  // With the delay model, a read only refreshes when a full conversion elapsed.
  task automatic expect_frame(input logic [11:0] t, input logic o, output logic [15:0] e);
    if (!DELAY_EN) begin
      e = model_frame(t, o);
    end else begin
      if ((cyc - last_ref) >= CONV + 20) prev_frame = model_frame(t, o);
      e = prev_frame;
    end
  endtask

  task automatic shift_bits(input int n, input bit idle_high, input int half,
                            output logic [31:0] word);
    word = 32'h0;
    if (idle_high) begin
      sclk = 1'b0;
      tick(half);
    end
    for (int i = 0; i < n; i++) begin
      word = {word[30:0], miso};
      sclk = 1'b1;
      tick(half);
      if (!idle_high || i < n - 1) begin
        sclk = 1'b0;
        tick(half);
      end
    end
  endtask

  task automatic end_frame(input string tag, input int nrise);
    int pulses;
    pulses = 0;
    cs = 1'b1;
    last_ref = cyc;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (frame_done === 1'b1) pulses++;
      if (k == 3) begin
        check({tag, "_oe_off"}, {31'h0, miso_oe}, 32'd0);
        check({tag, "_miso_off"}, {31'h0, miso}, 32'd0);
      end
    end
    check({tag, "_done"}, pulses, (nrise >= 16) ? 32'd1 : 32'd0);
  endtask

  task automatic host_read(input logic [11:0] t, input logic o, input bit idle_high,
                           input int half, input int nrise, input string tag);
    logic [15:0] e;
    logic [31:0] word;
    logic [31:0] exp_word;
    temp_code = t;
    tc_open   = o;
    sclk      = idle_high;
    tick(6);
    expect_frame(t, o, e);
    cs = 1'b0;
    tick(4);
    check({tag, "_oe_on"}, {31'h0, miso_oe}, 32'd1);
    shift_bits(nrise, idle_high, half, word);
    if (nrise <= 16) exp_word = {16'h0, e} >> (16 - nrise);
    else             exp_word = {16'h0, e} << (nrise - 16);
    check({tag, "_word"}, word, exp_word);
    end_frame(tag, nrise);
  endtask

  initial begin
    logic [15:0] e;
    logic [31:0] word;
    int          k;
    int          gap;

    tick(3);
    check("rst_miso", {31'h0, miso}, 32'd0);
    check("rst_oe", {31'h0, miso_oe}, 32'd0);
    check("rst_done", {31'h0, frame_done}, 32'd0);
    check("rst_ready", {31'h0, conv_ready}, 32'd0);
    rst = 1'b0;
    last_ref = cyc;
    prev_frame = 16'h0000;
    tick(2);
    check("ready_early", {31'h0, conv_ready}, DELAY_EN ? 32'd0 : 32'd1);

    while (cyc - last_ref < 500) tick(1);
    host_read(12'($urandom_range(1, 4095)), 1'($urandom_range(0, 1)), 1'b1, 4, 16, "early");

    k = 0;
    while (conv_ready !== 1'b1 && k < CONV + 100) begin
      tick(1);
      k++;
    end
    check("ready_rise", {31'h0, conv_ready}, 32'd1);
    tick(30);
    host_read(12'h064, 1'b0, 1'b1, 5, 16, "t064");
    tick(10);
    host_read(12'hFFF, 1'b1, 1'b0, 4, 16, "tfff");

    tick(CONV + 200);
    host_read(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 1'b0, 4, 8, "abort");
    check("abort_ready", {31'h0, conv_ready}, DELAY_EN ? 32'd0 : 32'd1);

    tick(CONV + 200);
    host_read(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 1'b1, 4, 20, "over20");

    // Reset in the middle of a frame with cs held low.
    tick(CONV + 200);
    temp_code = 12'($urandom_range(0, 4095));
    tc_open   = 1'($urandom_range(0, 1));
    sclk = 1'b1;
    tick(6);
    cs = 1'b0;
    tick(4);
    shift_bits(5, 1'b1, 4, word);
    rst = 1'b1;
    #1;
    check("midrst_miso", {31'h0, miso}, 32'd0);
    check("midrst_oe", {31'h0, miso_oe}, 32'd0);
    check("midrst_ready", {31'h0, conv_ready}, 32'd0);
    tick(2);
    rst = 1'b0;
    last_ref = cyc;
    prev_frame = 16'h0000;
    expect_frame(temp_code, tc_open, e);
    tick(2);
    check("midrst_lat2", {31'h0, miso_oe}, 32'd0);
    tick(1);
    check("midrst_lat3_oe", {31'h0, miso_oe}, 32'd1);
    check("midrst_lat3_d15", {31'h0, miso}, {31'h0, e[15]});
    shift_bits(16, 1'b1, 4, word);
    check("midrst_word", word, {16'h0, e});
    end_frame("midrst", 16);

    for (int i = 0; i < 6; i++) begin
      gap = ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 200))
                                        : CONV + int'($urandom_range(100, 300));
      tick(gap);
      host_read(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), int'($urandom_range(4, 7)), 16, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
